// File: rtl/mem_stage_unit_if.sv
// Data-memory bus between mem_stage_unit (master) and the data memory (slave).
// One outstanding request; the master holds the request fields stable until dmem_ack.
interface mem_stage_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output dmem_be,
      input  dmem_ack,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_be,
      output dmem_ack,
      output dmem_rdata
   );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: drives the data-memory bus, stalls upstream while waiting, fills the WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_stage_unit #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [31:0]      in_pc,
   input  logic             in_mem_read,
   input  logic             in_mem_write,
   input  logic [2:0]       in_func3,
   input  logic [31:0]      in_alu_out,
   input  logic [31:0]      in_rd2,
   input  logic [31:0]      in_write_reg,
   input  logic             in_mem_to_reg,
   input  logic             in_reg_write,
   output logic             stall_o,
   mem_stage_unit_if.master dmem,
   output logic             wb_valid,
   output logic [31:0]      wb_pc,
   output logic [31:0]      wb_alu_out,
   output logic [31:0]      wb_rdata,
   output logic [31:0]      wb_write_reg,
   output logic             wb_mem_to_reg,
   output logic             wb_reg_write,
   output logic             bus_err_o,
   output logic             misalign_o
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Request fields captured on entry to WAIT so the bus stays stable regardless of upstream.
   logic            lat_we_q;
   logic [31:0]     lat_addr_q;
   logic [31:0]     lat_wdata_q;
   logic [3:0]      lat_be_q;
   logic [2:0]      lat_func3_q;
   logic [1:0]      lat_lo_q;

   logic            wb_valid_q, wb_valid_d;
   logic [31:0]     wb_pc_q, wb_pc_d;
   logic [31:0]     wb_alu_out_q, wb_alu_out_d;
   logic [31:0]     wb_rdata_q, wb_rdata_d;
   logic [31:0]     wb_write_reg_q, wb_write_reg_d;
   logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
   logic            wb_reg_write_q, wb_reg_write_d;
   logic            bus_err_q, bus_err_d;
   logic            misalign_q, misalign_d;

   logic            is_mem, is_store, misaligned;
   logic [1:0]      size, lo;
   logic [31:0]     word_addr, st_wdata;
   logic [3:0]      st_be;

   logic            req, we, stall, complete, timeout, trap;
   logic [31:0]     addr, wdata;
   logic [3:0]      be;
   logic [2:0]      ld_func3;
   logic [1:0]      ld_lo;

   assign is_mem    = in_valid & (in_mem_read | in_mem_write);
   assign is_store  = in_mem_write;
   assign size      = in_func3[1:0];
   assign lo        = in_alu_out[1:0];
   assign word_addr = {in_alu_out[31:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = is_mem & (((size == 2'b01) & lo[0]) | (size[1] & (|lo)));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = in_rd2;
      if (is_store) begin
         unique case (size)
            2'b00: begin
               st_be    = 4'b0001 << lo;
               st_wdata = {4{in_rd2[7:0]}};
            end
            2'b01: begin
               st_be    = 4'b0011 << {lo[1], 1'b0};
               st_wdata = {2{in_rd2[15:0]}};
            end
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] f3,
                                                input logic [1:0] a_lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{a_lo, 3'b000} +: 8];
      h = a_lo[1] ? rdata[31:16] : rdata[15:0];
      unique case (f3[1:0])
         2'b00:   return {{24{b[7] & ~f3[2]}}, b};
         2'b01:   return {{16{h[15] & ~f3[2]}}, h};
         default: return rdata;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req      = 1'b0;
      we       = 1'b0;
      addr     = '0;
      wdata    = '0;
      be       = '0;
      stall    = 1'b0;
      complete = 1'b0;
      timeout  = 1'b0;
      trap     = 1'b0;
      ld_func3 = in_func3;
      ld_lo    = lo;
      unique case (state_q)
         StIdle: begin
            if (is_mem && misaligned) begin
               complete = 1'b1;
               trap     = 1'b1;
            end else if (is_mem) begin
               req   = 1'b1;
               we    = is_store;
               addr  = word_addr;
               wdata = st_wdata;
               be    = st_be;
               if (dmem.dmem_ack) begin
                  complete = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = StWait;
                  cnt_d   = '0;
               end
            end
         end
         StWait: begin
            req      = 1'b1;
            we       = lat_we_q;
            addr     = lat_addr_q;
            wdata    = lat_wdata_q;
            be       = lat_be_q;
            ld_func3 = lat_func3_q;
            ld_lo    = lat_lo_q;
            // An ack in the final counted cycle still wins over the timeout.
            if (dmem.dmem_ack) begin
               complete = 1'b1;
               state_d  = StIdle;
            end else if (cnt_q == CntMax) begin
               complete = 1'b1;
               timeout  = 1'b1;
               state_d  = StIdle;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wb_valid_d      = 1'b0;
      wb_pc_d         = '0;
      wb_alu_out_d    = '0;
      wb_rdata_d      = '0;
      wb_write_reg_d  = '0;
      wb_mem_to_reg_d = 1'b0;
      wb_reg_write_d  = 1'b0;
      bus_err_d       = 1'b0;
      misalign_d      = 1'b0;
      if (complete) begin
         wb_valid_d      = 1'b1;
         wb_pc_d         = in_pc;
         wb_alu_out_d    = in_alu_out;
         wb_write_reg_d  = in_write_reg;
         wb_mem_to_reg_d = in_mem_to_reg;
         wb_reg_write_d  = in_reg_write & ~timeout & ~trap;
         if (!we && !timeout && !trap) begin
            wb_rdata_d = load_extract(dmem.dmem_rdata, ld_func3, ld_lo);
         end
         bus_err_d  = timeout;
         misalign_d = trap;
      end else if (!stall) begin
         wb_valid_d      = in_valid;
         wb_pc_d         = in_pc;
         wb_alu_out_d    = in_alu_out;
         wb_write_reg_d  = in_write_reg;
         wb_mem_to_reg_d = in_mem_to_reg;
         wb_reg_write_d  = in_reg_write & in_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_be_q    <= '0;
         lat_func3_q <= '0;
         lat_lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == StIdle && stall) begin
            lat_we_q    <= we;
            lat_addr_q  <= addr;
            lat_wdata_q <= wdata;
            lat_be_q    <= be;
            lat_func3_q <= in_func3;
            lat_lo_q    <= lo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q      <= 1'b0;
         wb_pc_q         <= '0;
         wb_alu_out_q    <= '0;
         wb_rdata_q      <= '0;
         wb_write_reg_q  <= '0;
         wb_mem_to_reg_q <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         bus_err_q       <= 1'b0;
         misalign_q      <= 1'b0;
      end else begin
         wb_valid_q      <= wb_valid_d;
         wb_pc_q         <= wb_pc_d;
         wb_alu_out_q    <= wb_alu_out_d;
         wb_rdata_q      <= wb_rdata_d;
         wb_write_reg_q  <= wb_write_reg_d;
         wb_mem_to_reg_q <= wb_mem_to_reg_d;
         wb_reg_write_q  <= wb_reg_write_d;
         bus_err_q       <= bus_err_d;
         misalign_q      <= misalign_d;
      end
   end

   // Combinational bus/stall outputs are forced low while reset is asserted.
   assign dmem.dmem_req   = req & rst_n;
   assign dmem.dmem_we    = we & rst_n;
   assign dmem.dmem_addr  = rst_n ? addr : '0;
   assign dmem.dmem_wdata = rst_n ? wdata : '0;
   assign dmem.dmem_be    = rst_n ? be : '0;
   assign stall_o         = stall & rst_n;

   assign wb_valid      = wb_valid_q;
   assign wb_pc         = wb_pc_q;
   assign wb_alu_out    = wb_alu_out_q;
   assign wb_rdata      = wb_rdata_q;
   assign wb_write_reg  = wb_write_reg_q;
   assign wb_mem_to_reg = wb_mem_to_reg_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign bus_err_o     = bus_err_q;
   assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed vector table, reset corner case, and
// randomized accesses checked against a behavioural model.
module tb_mem_stage_unit;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write;
   logic [31:0] in_pc, in_alu_out, in_rd2, in_write_reg;
   logic [2:0]  in_func3;
   logic        stall_o, wb_valid, wb_mem_to_reg, wb_reg_write, bus_err_o, misalign_o;
   logic [31:0] wb_pc, wb_alu_out, wb_rdata, wb_write_reg;

   int checks = 0;
   int errors = 0;

   mem_stage_unit_if dmem_bus ();

   mem_stage_unit #(.TIMEOUT(T)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_pc         (in_pc),
      .in_mem_read   (in_mem_read),
      .in_mem_write  (in_mem_write),
      .in_func3      (in_func3),
      .in_alu_out    (in_alu_out),
      .in_rd2        (in_rd2),
      .in_write_reg  (in_write_reg),
      .in_mem_to_reg (in_mem_to_reg),
      .in_reg_write  (in_reg_write),
      .stall_o       (stall_o),
      .dmem          (dmem_bus),
      .wb_valid      (wb_valid),
      .wb_pc         (wb_pc),
      .wb_alu_out    (wb_alu_out),
      .wb_rdata      (wb_rdata),
      .wb_write_reg  (wb_write_reg),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_reg_write  (wb_reg_write),
      .bus_err_o     (bus_err_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] rd2;
      logic [31:0] rdata;
      int          lat;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      int          exp_stall;
      logic        exp_err;
      logic        exp_mis;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] f3, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] rd2,
                               input logic [31:0] rdata, input int lat, input logic exp_req,
                               input logic [31:0] exp_addr, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                               input int exp_stall, input logic exp_err, input logic exp_mis);
      vec_t v;
      v.f3 = f3; v.rd = rd; v.wr = wr; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
      v.lat = lat; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_be = exp_be;
      v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_stall = exp_stall;
      v.exp_err = exp_err; v.exp_mis = exp_mis;
      return v;
   endfunction

   // Reference model: expected bus fields and WB data from the access rules, in plain arithmetic.
   function automatic void model(inout vec_t v);
      int          sz, lane, half;
      logic [31:0] val;
      logic        mis;
      sz   = int'(v.f3 % 4);
      lane = int'(v.addr % 4);
      half = int'((v.addr / 2) % 2);
      mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis = (sz == 1 && (v.addr % 2) != 0) || (sz >= 2 && (v.addr % 4) != 0);
`endif
      v.exp_mis = 1'b0; v.exp_err = 1'b0; v.exp_req = 1'b0; v.exp_stall = 0;
      v.exp_addr = v.addr - (v.addr % 4); v.exp_be = 4'hF; v.exp_wdata = v.rd2;
      v.exp_rdata = 32'h0;
      if (!(v.rd || v.wr)) return;
      if (mis) begin
         v.exp_mis = 1'b1;
         return;
      end
      v.exp_req   = 1'b1;
      v.exp_stall = (v.lat < T) ? v.lat : T;
      v.exp_err   = (v.lat > T);
      if (v.wr) begin
         if (sz == 0) begin
            v.exp_be    = 4'(1 << lane);
            v.exp_wdata = (v.rd2 % 256) * 32'h0101_0101;
         end else if (sz == 1) begin
            v.exp_be    = 4'(3 << (2 * half));
            v.exp_wdata = (v.rd2 % 65536) * 32'h0001_0001;
         end
         return;
      end
      if (sz == 0) begin
         val = (v.rdata >> (8 * lane)) % 256;
         if (!v.f3[2] && val >= 128) val = val + 32'hFFFF_FF00;
      end else if (sz == 1) begin
         val = (v.rdata >> (16 * half)) % 65536;
         if (!v.f3[2] && val >= 32768) val = val + 32'hFFFF_0000;
      end else begin
         val = v.rdata;
      end
      if (!v.exp_err) v.exp_rdata = val;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_func3 = 3'd0;
      in_pc = '0; in_alu_out = '0; in_rd2 = '0; in_write_reg = '0;
      in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
      dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
   endtask

   // Applies one instruction at posedge+1 and follows it to completion.
   task automatic run_vec(input vec_t v, input logic [31:0] pc, input logic [31:0] wreg,
                          input logic regw, input logic mtr);
      int   stalls = 0;
      logic done = 1'b0;
      logic st;
      in_valid = 1'b1; in_pc = pc; in_mem_read = v.rd; in_mem_write = v.wr; in_func3 = v.f3;
      in_alu_out = v.addr; in_rd2 = v.rd2; in_write_reg = wreg; in_mem_to_reg = mtr;
      in_reg_write = regw;
      for (int idx = 0; idx < 40 && !done; idx++) begin
         dmem_bus.dmem_ack   = (idx == v.lat);
         dmem_bus.dmem_rdata = v.rdata;
         @(negedge clk);
         st = stall_o;
         chk("dmem_req", {31'd0, dmem_bus.dmem_req}, {31'd0, v.exp_req});
         if (v.exp_req) begin
            chk("dmem_addr", dmem_bus.dmem_addr, v.exp_addr);
            chk("dmem_be", {28'd0, dmem_bus.dmem_be}, {28'd0, v.exp_be});
            chk("dmem_we", {31'd0, dmem_bus.dmem_we}, {31'd0, v.wr});
            if (v.wr) chk("dmem_wdata", dmem_bus.dmem_wdata, v.exp_wdata);
         end
         @(posedge clk);
         #1;
         if (st) begin
            stalls++;
            chk("bubble_valid", {31'd0, wb_valid}, 32'd0);
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL completion_bound: no completion within 40 cycles (addr %h)", v.addr);
      end
      chk("stall_cycles", 32'(stalls), 32'(v.exp_stall));
      chk("wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("wb_pc", wb_pc, pc);
      chk("wb_alu_out", wb_alu_out, v.addr);
      chk("wb_write_reg", wb_write_reg, wreg);
      chk("wb_mem_to_reg", {31'd0, wb_mem_to_reg}, {31'd0, mtr});
      chk("wb_rdata", wb_rdata, v.exp_rdata);
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, regw & ~v.exp_err & ~v.exp_mis});
      chk("bus_err_o", {31'd0, bus_err_o}, {31'd0, v.exp_err});
      chk("misalign_o", {31'd0, misalign_o}, {31'd0, v.exp_mis});
      idle_inputs();
   endtask

   initial begin
      vec_t tbl[11];
      vec_t r;
      int   kind;
      logic [2:0] ld_f3[5];
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

      //        f3  rd wr addr        rd2           rdata         lat req eaddr      be
      //        wdata         rdata         stall err mis
      tbl[0]  = mk(3'd2, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 32'h100, 4'hF,
                   32'h0, 32'hDEADBEEF, 0, 0, 0);
      tbl[1]  = mk(3'd0, 1, 0, 32'h103, 32'h0, 32'h80000000, 3, 1, 32'h100, 4'hF,
                   32'h0, 32'hFFFFFF80, 3, 0, 0);
      tbl[2]  = mk(3'd4, 1, 0, 32'h103, 32'h0, 32'h80000000, 3, 1, 32'h100, 4'hF,
                   32'h0, 32'h00000080, 3, 0, 0);
      tbl[3]  = mk(3'd1, 0, 1, 32'h202, 32'h1234ABCD, 32'h0, 1, 1, 32'h200, 4'hC,
                   32'hABCDABCD, 32'h0, 1, 0, 0);
      tbl[4]  = mk(3'd2, 0, 1, 32'h300, 32'hCAFEF00D, 32'h0, 99, 1, 32'h300, 4'hF,
                   32'hCAFEF00D, 32'h0, 4, 1, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      tbl[5]  = mk(3'd2, 1, 0, 32'h101, 32'h0, 32'h11223344, 0, 0, 32'h100, 4'hF,
                   32'h0, 32'h0, 0, 0, 1);
`else
      tbl[5]  = mk(3'd2, 1, 0, 32'h101, 32'h0, 32'h11223344, 0, 1, 32'h100, 4'hF,
                   32'h0, 32'h11223344, 0, 0, 0);
`endif
      tbl[6]  = mk(3'd1, 1, 0, 32'h102, 32'h0, 32'h80010000, 0, 1, 32'h100, 4'hF,
                   32'h0, 32'hFFFF8001, 0, 0, 0);
      tbl[7]  = mk(3'd5, 1, 0, 32'h102, 32'h0, 32'h80010000, 0, 1, 32'h100, 4'hF,
                   32'h0, 32'h00008001, 0, 0, 0);
      tbl[8]  = mk(3'd0, 1, 1, 32'h101, 32'h000000A5, 32'h0, 2, 1, 32'h100, 4'h2,
                   32'hA5A5A5A5, 32'h0, 2, 0, 0);
      tbl[9]  = mk(3'd2, 1, 0, 32'h400, 32'h0, 32'h5A5A0F0F, 4, 1, 32'h400, 4'hF,
                   32'h0, 32'h5A5A0F0F, 4, 0, 0);
      tbl[10] = mk(3'd0, 0, 0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 0, 0, 32'h0, 4'h0,
                   32'h0, 32'h0, 0, 0, 0);

      // Reset state with a memory op presented: every output must stay low.
      idle_inputs();
      in_valid = 1'b1; in_mem_read = 1'b1; in_func3 = 3'd2; in_alu_out = 32'h100;
      in_reg_write = 1'b1;
      #3;
      chk("rst_dmem_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_dmem_be", {28'd0, dmem_bus.dmem_be}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         run_vec(tbl[i], 32'h1000 + 32'(4 * i), 32'(i + 1), 1'b1, tbl[i].rd);
      end

      // Reset in the 2nd WAIT cycle of a load, then a late ack after release.
      in_valid = 1'b1; in_mem_read = 1'b1; in_func3 = 3'd2; in_alu_out = 32'h500;
      in_reg_write = 1'b1; dmem_bus.dmem_rdata = 32'h77777777;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_dmem_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
      chk("midrst_stall", {31'd0, stall_o}, 32'd0);
      chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      rst_n = 1'b1;
      dmem_bus.dmem_ack = 1'b1;
      dmem_bus.dmem_rdata = 32'h77777777;
      @(negedge clk);
      chk("late_ack_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
      chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("late_ack_wb_rdata", wb_rdata, 32'd0);
      chk("late_ack_bus_err", {31'd0, bus_err_o}, 32'd0);
      dmem_bus.dmem_ack = 1'b0;
      run_vec(tbl[1], 32'h2000, 32'd7, 1'b1, 1'b1);

      // Randomized accesses against the model.
      for (int n = 0; n < 60; n++) begin
         kind    = int'($urandom_range(0, 2));
         r.addr  = $urandom;
         r.rd2   = $urandom;
         r.rdata = $urandom;
         r.lat   = int'($urandom_range(0, 6));
         if (kind == 0) begin
            r.rd = 1'b0; r.wr = 1'b0; r.f3 = 3'($urandom_range(0, 7));
         end else if (kind == 1) begin
            r.rd = 1'b1; r.wr = 1'b0; r.f3 = ld_f3[$urandom_range(0, 4)];
         end else begin
            r.rd = 1'($urandom_range(0, 1)); r.wr = 1'b1; r.f3 = 3'($urandom_range(0, 2));
         end
         model(r);
         run_vec(r, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_stage_unit.md
MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 64, giving the maximum number of wait cycles for dmem_ack before a bus error is declared.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have the following MEM-stage inputs: in_valid (1), in_pc (32), in_mem_read (1), in_mem_write (1), in_func3 (3, access size/sign), in_alu_out (32, address or ALU result), in_rd2 (32, store data), in_write_reg (32, destination index; low 5 bits significant), in_mem_to_reg (1), in_reg_write (1).
REQ-005 SHALL have output stall_o, 1 bit, which freezes the upstream pipeline registers.
REQ-006 SHALL have the following data-memory ports: dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, 32, word-aligned), dmem_wdata (out, 32), dmem_be (out, 4), dmem_ack (in, 1), dmem_rdata (in, 32).
REQ-007 SHALL have the following write-back register outputs: wb_valid (1), wb_pc (32), wb_alu_out (32), wb_rdata (32), wb_write_reg (32), wb_mem_to_reg (1), wb_reg_write (1).
REQ-008 SHALL have status outputs bus_err_o (1) and misalign_o (1), each a 1-cycle pulse aligned with wb_valid.

Function
REQ-009 SHALL treat an instruction as a memory op when in_valid=1 and (in_mem_read|in_mem_write)=1; in_mem_write SHALL take priority if both are set.
REQ-010 SHALL latch a non-memory op into the WB register on the next edge (latency 1), with wb_rdata=0 and stall_o=0.
REQ-011 SHALL implement the FSM states IDLE and WAIT.
- IDLE with a memory op: dmem_req=1 combinationally.
- dmem_ack=1 in the same cycle: complete the op, stay in IDLE (latency 1).
- Otherwise: move to WAIT.
REQ-012 In WAIT, SHALL hold dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stable until dmem_ack; on dmem_ack it SHALL complete the op and return to IDLE.
REQ-013 stall_o SHALL equal (memory op present) AND NOT (completing this cycle).
- While stalled, the WB register captures a bubble: wb_valid=0, wb_reg_write=0.
REQ-014 dmem_addr SHALL be {in_alu_out[31:2],2'b00}; dmem_be SHALL be as follows.
- SB: 4'b0001<<addr[1:0].
- SH: 4'b0011<<{addr[1],1'b0}.
- SW: 4'b1111.
- Loads: 4'b1111.
REQ-015 Store data SHALL be replicated per size: the byte in all 4 lanes, the halfword in both halves.
REQ-016 On load completion, SHALL select the lane by addr[1:0] and sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes dmem_rdata unchanged.
REQ-017 SHALL use a wait counter that clears on entry to WAIT and increments each WAIT cycle without ack.
- At TIMEOUT: pulse bus_err_o, drop dmem_req, complete the op with wb_reg_write=0, return to IDLE.
REQ-018 If dmem_ack arrives in the same cycle the counter reaches TIMEOUT, ack SHALL win and no error is raised.
REQ-019 dmem_ack received while dmem_req=0 SHALL be ignored.
REQ-020 Completion SHALL copy in_pc, in_alu_out, in_write_reg, in_mem_to_reg and in_reg_write into the WB register, with wb_valid=1.

Reset
REQ-021 rst_n=0 SHALL immediately force state to IDLE, clear the counter, and drive every output (including dmem_req and stall_o) to 0.
REQ-022 A reset mid-WAIT SHALL abandon the access; a dmem_ack arriving after reset release SHALL be ignored per REQ-019.

Configuration
REQ-023 When MEM_MISALIGN_TRAP_EN is defined, the block SHALL detect misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) and handle them as follows.
- Issue no dmem_req.
- Complete in 1 cycle with misalign_o=1 and wb_reg_write=0.
REQ-024 When MEM_MISALIGN_TRAP_EN is undefined, the block SHALL apply the following behaviour.
- Halfword accesses ignore addr[0].
- Word accesses ignore addr[1:0].
- misalign_o is tied to 0.

Verification
REQ-025 LW, addr 0x100, ack same cycle, rdata 0xDEADBEEF -> stall_o=0; next cycle wb_rdata=0xDEADBEEF, wb_valid=1.
REQ-026 LB, addr 0x103, ack after 3 wait cycles, rdata 0x80000000 -> stall_o high 3 cycles, dmem_be=4'b1111, wb_rdata=0xFFFFFF80; the LBU equivalent gives 0x00000080.
REQ-027 SH, addr 0x202, rd2 0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-028 SW with no ack, TIMEOUT=4 -> stall_o high 4 cycles, then bus_err_o pulse, wb_reg_write=0, dmem_req=0.
REQ-029 rst_n low in the 2nd WAIT cycle of a load -> dmem_req=0 and stall_o=0 immediately; a late ack has no effect.
REQ-030 With MEM_MISALIGN_TRAP_EN, LW at addr 0x101 -> no dmem_req, misalign_o=1, wb_reg_write=0; without the macro -> access to 0x100 with dmem_be=4'b1111.
